// File: rtl/ir_nec_pkg.sv
// ir_nec_pkg: shared definitions for the NEC infrared transmitter.
//   - one-hot FSM state encoding
//   - default envelope timing in clk10KHz ticks (100 us each)
//   - frame size and counter widths
package ir_nec_pkg;

    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_LEAD_M = 6'b000010,
        ST_LEAD_S = 6'b000100,
        ST_BIT_M  = 6'b001000,
        ST_BIT_S  = 6'b010000,
        ST_STOP_M = 6'b100000
    } nec_state_t;

    localparam int DEF_LEAD_MARK  = 90;  // 9.0 ms
    localparam int DEF_LEAD_SPACE = 45;  // 4.5 ms
    localparam int DEF_BIT_MARK   = 6;
    localparam int DEF_ZERO_SPACE = 6;
    localparam int DEF_ONE_SPACE  = 17;

    localparam int NEC_FRAME_BITS = 32;
    localparam int CNT_W          = 7;   // holds 90-1
    localparam int IDX_W          = 5;   // 0..31

endpackage

// File: rtl/ir_tick_timer.sv
// ir_tick_timer: loadable down-counter that stops at zero.
//   clk10KHz : block clock
//   rst      : asynchronous active-low reset (counter -> 0)
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : value loaded, i.e. (duration - 1)
//   zero     : counter currently reads 0
module ir_tick_timer #(
    parameter int CNT_W = 7
) (
    input  logic             clk10KHz,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk10KHz or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ir_nec_tx.sv
// ir_nec_tx: NEC-protocol IR transmitter producing a mark/space envelope.
//   clk10KHz : block clock, 100 us tick
//   rst      : asynchronous active-low reset
//   start    : send request, sampled only while idle
//   addr/cmd : NEC address / command, latched when start is accepted
//   busy     : high while a frame is in progress
//   done     : one-cycle pulse as the frame completes
//   ir_env   : envelope, 1 = mark (carrier on), 0 = space
module ir_nec_tx
    import ir_nec_pkg::*;
#(
    parameter int LEAD_MARK  = DEF_LEAD_MARK,
    parameter int LEAD_SPACE = DEF_LEAD_SPACE,
    parameter int BIT_MARK   = DEF_BIT_MARK,
    parameter int ZERO_SPACE = DEF_ZERO_SPACE,
    parameter int ONE_SPACE  = DEF_ONE_SPACE
) (
    input  logic       clk10KHz,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] cmd,
    output logic       busy,
    output logic       done,
    output logic       ir_env
);

    localparam logic [CNT_W-1:0] LM_LOAD = CNT_W'(LEAD_MARK - 1);
    localparam logic [CNT_W-1:0] LS_LOAD = CNT_W'(LEAD_SPACE - 1);
    localparam logic [CNT_W-1:0] BM_LOAD = CNT_W'(BIT_MARK - 1);
    localparam logic [CNT_W-1:0] ZS_LOAD = CNT_W'(ZERO_SPACE - 1);
    localparam logic [CNT_W-1:0] OS_LOAD = CNT_W'(ONE_SPACE - 1);

    nec_state_t                state;
    logic [NEC_FRAME_BITS-1:0] shreg;
    logic [IDX_W-1:0]          bit_idx;
    logic                      t_load;
    logic [CNT_W-1:0]          t_val;
    logic                      t_zero;
    logic                      last_bit;

    assign last_bit = (bit_idx == IDX_W'(NEC_FRAME_BITS - 1));

    ir_tick_timer #(.CNT_W(CNT_W)) u_timer (
        .clk10KHz (clk10KHz),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    // Reload the timer on every state entry with (length - 1) of the state
    // being entered. BIT_S -> BIT_M and BIT_S -> STOP_M share the mark length.
    always_comb begin
        t_load = 1'b0;
        t_val  = '0;
        unique case (state)
            ST_IDLE: begin
                t_load = start;
                t_val  = LM_LOAD;
            end
            ST_LEAD_M: begin
                t_load = t_zero;
                t_val  = LS_LOAD;
            end
            ST_LEAD_S: begin
                t_load = t_zero;
                t_val  = BM_LOAD;
            end
            ST_BIT_M: begin
                t_load = t_zero;
                t_val  = shreg[0] ? OS_LOAD : ZS_LOAD;
            end
            ST_BIT_S: begin
                t_load = t_zero;
                t_val  = BM_LOAD;
            end
            default: begin
                t_load = 1'b0;
                t_val  = '0;
            end
        endcase
    end

    // Outputs are registered from the current state, so they follow the
    // state by one cycle: a frame accepted at edge T shows ir_env/busy from
    // T+1, and done fires on the first idle cycle after a busy one.
    always_ff @(posedge clk10KHz or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            ir_env  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            ir_env <= (state == ST_LEAD_M) || (state == ST_BIT_M) ||
                      (state == ST_STOP_M);
            busy   <= (state != ST_IDLE);
            done   <= (state == ST_IDLE) && busy;

            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        // LSB-first order on air: addr, ~addr, cmd, ~cmd
                        shreg   <= {~cmd, cmd, ~addr, addr};
                        bit_idx <= '0;
                        state   <= ST_LEAD_M;
                    end
                end
                ST_LEAD_M: if (t_zero) state <= ST_LEAD_S;
                ST_LEAD_S: if (t_zero) state <= ST_BIT_M;
                ST_BIT_M:  if (t_zero) state <= ST_BIT_S;
                ST_BIT_S: begin
                    if (t_zero) begin
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + IDX_W'(1);
                        state   <= last_bit ? ST_STOP_M : ST_BIT_M;
                    end
                end
                ST_STOP_M: if (t_zero) state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_nec_tx.sv
`timescale 1us/1ns
// tb_ir_nec_tx: scoreboard bench for the NEC transmitter.
// Stimulus pushes expected envelope segments and frame lengths; monitors
// measure the DUT envelope at negedges and compare against the queues.
module tb_ir_nec_tx;

    logic       clk10KHz = 1'b0;
    logic       rst      = 1'b0;
    logic       start    = 1'b0;
    logic       start2   = 1'b0;
    logic [7:0] addr     = 8'h00;
    logic [7:0] cmd      = 8'h00;
    logic       busy, done, ir_env;
    logic       busy2, done2, ir_env2;

    always #50 clk10KHz = ~clk10KHz;

    ir_nec_tx dut (
        .clk10KHz (clk10KHz),
        .rst      (rst),
        .start    (start),
        .addr     (addr),
        .cmd      (cmd),
        .busy     (busy),
        .done     (done),
        .ir_env   (ir_env)
    );

    ir_nec_tx #(.LEAD_MARK(10)) dut2 (
        .clk10KHz (clk10KHz),
        .rst      (rst),
        .start    (start2),
        .addr     (addr),
        .cmd      (cmd),
        .busy     (busy2),
        .done     (done2),
        .ir_env   (ir_env2)
    );

    typedef struct packed {
        logic        lvl;
        logic [31:0] len;
    } seg_t;

    seg_t seg_q[$];
    int   len_q[$];
    int   lead2_q[$];
    int   len2_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected envelope of one frame for a hand-computed 32-bit word
    // {~cmd, cmd, ~addr, addr}, sent LSB first.
    task automatic push_frame(input logic [31:0] word, input int lead);
        seg_q.push_back('{lvl: 1'b1, len: 32'(lead)});
        seg_q.push_back('{lvl: 1'b0, len: 32'd45});
        for (int i = 0; i < 32; i++) begin
            seg_q.push_back('{lvl: 1'b1, len: 32'd6});
            seg_q.push_back('{lvl: 1'b0, len: word[i] ? 32'd17 : 32'd6});
        end
        seg_q.push_back('{lvl: 1'b1, len: 32'd6});
        len_q.push_back(lead + 611);
    endtask

    // ---------------- monitor for dut ----------------
    logic m_prev_env  = 1'b0;
    logic m_prev_done = 1'b0;
    logic m_sp_in     = 1'b0;
    int   m_run       = 0;
    int   m_bcnt      = 0;
    int   m_seg_no    = 0;

    task automatic pop_seg(input logic lvl, input int run);
        seg_t s;
        if (seg_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL seg_unexpected: got level %0d length %0d, expected no segment", lvl, run);
        end else begin
            s = seg_q.pop_front();
            chk($sformatf("seg%0d_level", m_seg_no), int'(lvl), int'(s.lvl));
            chk($sformatf("seg%0d_len", m_seg_no), run, int'(s.len));
        end
        m_seg_no++;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk10KHz);
            if (!rst) begin
                m_prev_env  = 1'b0;
                m_prev_done = 1'b0;
                m_sp_in     = 1'b0;
                m_run       = 0;
                m_bcnt      = 0;
            end else begin
                if (m_prev_done) chk("done_width", int'(done), 0);
                if (ir_env !== m_prev_env) begin
                    if (m_prev_env) begin
                        pop_seg(1'b1, m_run);
                        m_sp_in = busy;  // space inside a frame only while busy
                    end else if (m_sp_in) begin
                        pop_seg(1'b0, m_run);
                    end
                    m_run = 1;
                end else begin
                    m_run++;
                end
                if (busy) m_bcnt++;
                if (done) begin
                    chk("done_with_env_fall", int'({m_prev_env, ir_env}), 2);
                    if (len_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done_unexpected: got done after %0d busy cycles, expected no done", m_bcnt);
                    end else begin
                        chk("frame_len", m_bcnt, len_q.pop_front());
                    end
                    m_bcnt = 0;
                end
                m_prev_env  = ir_env;
                m_prev_done = done;
            end
        end
    end

    // ---------------- monitor for dut2 (LEAD_MARK=10) ----------------
    logic m2_prev_env = 1'b0;
    int   m2_run      = 0;
    int   m2_first    = -1;
    int   m2_bcnt     = 0;

    initial begin : monitor2
        forever begin
            @(negedge clk10KHz);
            if (!rst) begin
                m2_prev_env = 1'b0;
                m2_run      = 0;
                m2_first    = -1;
                m2_bcnt     = 0;
            end else begin
                if (ir_env2 !== m2_prev_env) begin
                    if (m2_prev_env && m2_first < 0) m2_first = m2_run;
                    m2_run = 1;
                end else begin
                    m2_run++;
                end
                if (busy2) m2_bcnt++;
                if (done2) begin
                    if (lead2_q.size() == 0 || len2_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done2_unexpected: got done after %0d busy cycles, expected no done", m2_bcnt);
                    end else begin
                        chk("p_lead_mark", m2_first, lead2_q.pop_front());
                        chk("p_frame_len", m2_bcnt, len2_q.pop_front());
                    end
                    m2_first = -1;
                    m2_bcnt  = 0;
                end
                m2_prev_env = ir_env2;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] a, input logic [7:0] c,
                        input logic [31:0] word);
        push_frame(word, 90);
        @(negedge clk10KHz);
        addr  = a;
        cmd   = c;
        start = 1'b1;
        @(negedge clk10KHz);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk10KHz);
            if (seg_q.size() == 0 && len_q.size() == 0 && !busy) break;
        end
        chk({name, "_drained"}, int'(i < budget), 1);
    endtask

    initial begin : stim
        int k;
        // reset state
        repeat (3) @(posedge clk10KHz);
        #1;
        chk("rst_env", int'(ir_env), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk10KHz);
        rst = 1'b1;
        repeat (5) @(negedge clk10KHz);
        chk("idle_busy", int'(busy), 0);

        // basic frame: addr 0x00 cmd 0x45
        send(8'h00, 8'h45, 32'hBA45_FF00);
        wait_idle("basic", 1000);

        // start pulsed again mid-frame is ignored
        send(8'hA5, 8'h3C, 32'hC33C_5AA5);
        repeat (298) @(negedge clk10KHz);
        start = 1'b1;
        @(negedge clk10KHz);
        start = 1'b0;
        wait_idle("ignore", 1000);
        repeat (100) @(negedge clk10KHz);
        chk("ignore_no_refire", int'(busy), 0);

        // start held high: two back-to-back frames
        push_frame(32'h7E81_A55A, 90);
        push_frame(32'h7E81_A55A, 90);
        @(negedge clk10KHz);
        addr  = 8'h5A;
        cmd   = 8'h81;
        start = 1'b1;
        for (k = 0; k < 800; k++) begin
            @(negedge clk10KHz);
            if (done) break;
        end
        chk("b2b_first_done_seen", int'(k < 800), 1);
        @(negedge clk10KHz);
        chk("b2b_env_restart", int'(ir_env), 1);
        chk("b2b_busy_restart", int'(busy), 1);
        repeat (100) @(negedge clk10KHz);
        start = 1'b0;
        wait_idle("b2b", 2000);

        // asynchronous reset inside the data bits
        send(8'h00, 8'h45, 32'hBA45_FF00);
        repeat (150) @(posedge clk10KHz);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_env", int'(ir_env), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        seg_q.delete();
        len_q.delete();
        repeat (10) @(negedge clk10KHz);
        rst = 1'b1;
        repeat (60) @(negedge clk10KHz);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_env", int'(ir_env), 0);

        // addr/cmd changed after latching: frame still encodes 0x12/0x34
        send(8'h12, 8'h34, 32'hCB34_ED12);
        repeat (4) @(negedge clk10KHz);
        addr = 8'hFF;
        cmd  = 8'hFF;
        wait_idle("latch", 1000);

        // LEAD_MARK override on the second instance
        lead2_q.push_back(10);
        len2_q.push_back(621);
        @(negedge clk10KHz);
        start2 = 1'b1;
        @(negedge clk10KHz);
        start2 = 1'b0;
        for (k = 0; k < 900; k++) begin
            @(negedge clk10KHz);
            if (lead2_q.size() == 0 && !busy2) break;
        end
        chk("param_drained", int'(k < 900), 1);
        chk("dut_stays_idle", int'(busy), 0);
        chk("scoreboard_empty", seg_q.size() + len_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
